// File: rtl/spi_mem_master.sv
// SPI mode-0 initiator for the BNN shared memory: 6-bit {rw,addr} header, then burst writes or reads of 20-bit words.
// Optional request range check enabled by defining SPI_MEM_MASTER_RANGE_CHECK_EN.
module spi_mem_master #(
    parameter int CLK_DIV   = 4,
    parameter int MEM_DEPTH = 29
) (
    input  logic        CLOCK_50,
    input  logic        iRSTn,
    input  logic        iSTART,
    input  logic        iRW,
    input  logic [4:0]  iADDR,
    input  logic [4:0]  iLEN,
    input  logic [19:0] iDATA,
    output logic        oDATA_REQ,
    output logic [19:0] oDATA,
    output logic        oDATA_VALID,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        CS
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_HEADER, ST_TURN, ST_DATA, ST_HOLD, ST_DONE
    } state_t;

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HOLD_END = DIV_W'(2 * CLK_DIV - 1);

    if (CLK_DIV < 2 || MEM_DEPTH < 1 || MEM_DEPTH > 31) begin : g_param_check
        $error("spi_mem_master: unsupported CLK_DIV or MEM_DEPTH");
    end

    state_t           state_r;
    logic [DIV_W-1:0] div_r;
    logic [4:0]       bit_r;
    logic [4:0]       word_r;
    logic             rw_r;
    logic [19:0]      tx_r;
    logic [19:0]      rx_r;
    logic             rise_r;
    logic             miso_meta_r;
    logic             miso_sync_r;
    logic             sclk_r;
    logic             mosi_r;
    logic             cs_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             req_r;
    logic             valid_r;
    logic [19:0]      data_r;

    logic             half_end_s;
    logic [19:0]      rx_next_s;
    logic             range_bad_s;

    assign half_end_s = (div_r == HALF_END);
    assign rx_next_s  = {rx_r[18:0], miso_sync_r};

`ifdef SPI_MEM_MASTER_RANGE_CHECK_EN
    assign range_bad_s = ({1'b0, iADDR} >= 6'(MEM_DEPTH)) ||
                         (({1'b0, iADDR} + {1'b0, iLEN}) > 6'(MEM_DEPTH));
`else
    assign range_bad_s = 1'b0;
`endif

    assign SCLK        = sclk_r;
    assign MOSI        = mosi_r;
    assign CS          = cs_r;
    assign oBUSY       = busy_r;
    assign oDONE       = done_r;
    assign oERR        = err_r;
    assign oDATA_REQ   = req_r;
    assign oDATA_VALID = valid_r;
    assign oDATA       = data_r;

    // Two-flop synchroniser for the responder's data line.
    always_ff @(posedge CLOCK_50) begin
        if (!iRSTn) begin
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
        end else begin
            miso_meta_r <= MISO;
            miso_sync_r <= miso_meta_r;
        end
    end

    // Transfer sequencer: divider, bit/word counters, shifters and all registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!iRSTn) begin
            state_r <= ST_IDLE;
            div_r   <= '0;
            bit_r   <= 5'd0;
            word_r  <= 5'd0;
            rw_r    <= 1'b0;
            tx_r    <= 20'd0;
            rx_r    <= 20'd0;
            rise_r  <= 1'b0;
            sclk_r  <= 1'b0;
            mosi_r  <= 1'b0;
            cs_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= 20'd0;
        end else begin
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rise_r  <= 1'b0;

            // The cycle after a rise: sample MISO and take the write word requested at that rise.
            if (rise_r) begin
                rx_r <= rx_next_s;
                if (state_r == ST_DATA && !rw_r && bit_r == 5'd0) begin
                    data_r  <= rx_next_s;
                    valid_r <= 1'b1;
                end
            end
            if (req_r) begin
                tx_r <= iDATA;
            end

            case (state_r)
                ST_IDLE: begin
                    if (iSTART) begin
                        if (range_bad_s) begin
                            err_r <= 1'b1;
                        end else begin
                            rw_r   <= iRW;
                            word_r <= iLEN;
                            bit_r  <= 5'd5;
                            div_r  <= '0;
                            busy_r <= 1'b1;
                            if (iLEN == 5'd0) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_SETUP;
                                cs_r    <= 1'b0;
                                mosi_r  <= iRW;
                                tx_r    <= {iADDR, 15'd0};
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (half_end_s) begin
                        div_r   <= '0;
                        sclk_r  <= 1'b1;
                        rise_r  <= 1'b1;
                        state_r <= ST_HEADER;
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_HEADER, ST_TURN, ST_DATA: begin
                    div_r <= half_end_s ? '0 : div_r + DIV_W'(1);
                    if (half_end_s && !sclk_r) begin
                        sclk_r <= 1'b1;
                        rise_r <= 1'b1;
                        if (rw_r && bit_r == 5'd0 &&
                            (state_r == ST_HEADER || (state_r == ST_DATA && word_r != 5'd1))) begin
                            req_r <= 1'b1;
                        end
                    end else if (half_end_s) begin
                        // Falling edge: present the next bit; tx_r drains to zeros after the last word.
                        sclk_r <= 1'b0;
                        mosi_r <= tx_r[19];
                        tx_r   <= {tx_r[18:0], 1'b0};
                        if (bit_r != 5'd0) begin
                            bit_r <= bit_r - 5'd1;
                        end else begin
                            bit_r <= 5'd19;
                            case (state_r)
                                ST_HEADER: state_r <= rw_r ? ST_DATA : ST_TURN;
                                ST_TURN:   state_r <= ST_DATA;
                                ST_DATA: begin
                                    word_r <= word_r - 5'd1;
                                    if (word_r == 5'd1) begin
                                        state_r <= ST_HOLD;
                                    end
                                end
                                default:   state_r <= ST_IDLE;
                            endcase
                        end
                    end
                end
                ST_HOLD: begin
                    // Covers the last bit's low phase plus the CS hold time.
                    if (div_r == HOLD_END) begin
                        div_r   <= '0;
                        cs_r    <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// Self-checking bench for spi_mem_master with a bit-level SPI responder model and a word-level reference memory.
module tb_spi_mem_master;

    localparam int D     = 4;
    localparam int DEPTH = 29;

    logic        CLOCK_50 = 1'b0;
    logic        iRSTn    = 1'b0;
    logic        iSTART   = 1'b0;
    logic        iRW      = 1'b0;
    logic [4:0]  iADDR    = 5'd0;
    logic [4:0]  iLEN     = 5'd0;
    logic [19:0] iDATA    = 20'd0;
    logic        MISO     = 1'b0;
    logic        oDATA_REQ, oDATA_VALID, oBUSY, oDONE, oERR, SCLK, MOSI, CS;
    logic [19:0] oDATA;

    spi_mem_master #(.CLK_DIV(D), .MEM_DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50), .iRSTn(iRSTn), .iSTART(iSTART), .iRW(iRW),
        .iADDR(iADDR), .iLEN(iLEN), .iDATA(iDATA), .oDATA_REQ(oDATA_REQ),
        .oDATA(oDATA), .oDATA_VALID(oDATA_VALID), .oBUSY(oBUSY), .oDONE(oDONE),
        .oERR(oERR), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Responder memory (driven over the wire) and reference memory (updated from stimulus).
    logic [19:0] mem [32];
    logic [19:0] ref_mem [32];
    int          rk = 0;
    logic [5:0]  hdr = 6'd0;
    logic [19:0] wacc = 20'd0;

    // Monitor state
    bit          mosi_q [$];
    logic [19:0] rd_q [$];
    logic [19:0] wr_q [$];
    logic [19:0] stim_q [$];
    int req_cnt, done_cnt, done_cyc, err_cnt, err_cyc, cs_fall_cnt, cs_fall_cyc;
    int first_rise, busy_rise, cs_bad;
    logic cs_prev = 1'b1, sclk_prev = 1'b0, busy_prev = 1'b0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 20'd0;
            ref_mem[i] = 20'd0;
        end
    end

    // Responder: new window restarts its bit count.
    always @(negedge CS) rk = 0;

    // Responder: capture header and write bits on SCLK rise.
    always @(posedge SCLK) begin
        int j;
        mosi_q.push_back(MOSI);
        if (CS) cs_bad++;
        if (rk < 6) begin
            hdr = {hdr[4:0], MOSI};
        end else if (hdr[5]) begin
            j = rk - 6;
            wacc = {wacc[18:0], MOSI};
            if (j % 20 == 19) mem[(int'(hdr[4:0]) + j / 20) % 32] = wacc;
        end
        rk++;
    end

    // Responder: drive read bits on SCLK fall, after header and 20 turnaround bits.
    always @(negedge SCLK) begin
        int j;
        if (hdr[5] == 1'b0 && rk >= 26) begin
            j = rk - 26;
            MISO = mem[(int'(hdr[4:0]) + j / 20) % 32][19 - j % 20];
        end else begin
            MISO = 1'b0;
        end
    end

    // Output monitor and write-word source.
    always @(negedge CLOCK_50) begin
        if (oDATA_REQ) begin
            req_cnt++;
            iDATA = (wr_q.size() > 0) ? wr_q.pop_front() : 20'd0;
        end
        if (oDATA_VALID) rd_q.push_back(oDATA);
        if (oDONE) begin done_cnt++; done_cyc = cyc; end
        if (oERR)  begin err_cnt++;  err_cyc  = cyc; end
        if (!CS && cs_prev) begin cs_fall_cnt++; cs_fall_cyc = cyc; end
        if (SCLK && !sclk_prev && first_rise < 0) first_rise = cyc;
        if (oBUSY && !busy_prev && busy_rise < 0) busy_rise = cyc;
        cs_prev = CS; sclk_prev = SCLK; busy_prev = oBUSY;
    end

    task automatic clear_mon();
        mosi_q.delete(); rd_q.delete(); wr_q.delete();
        req_cnt = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        cs_fall_cnt = 0; cs_fall_cyc = -1; first_rise = -1; busy_rise = -1; cs_bad = 0;
    endtask

    // One transfer using words from stim_q (writes); checks timing, bit stream, handshakes and read data.
    task automatic do_transfer(input bit rw, input logic [4:0] addr, input int len, input string tag);
        bit   exp_q [$];
        logic [5:0] h;
        int a, n_bits, exp_done, nbad, lim;
        bit got;
        clear_mon();
        h = {rw, addr};
        for (int b = 5; b >= 0; b--) exp_q.push_back(h[b]);
        if (rw) begin
            for (int i = 0; i < len; i++) begin
                logic [19:0] w;
                w = stim_q.pop_front();
                wr_q.push_back(w);
                ref_mem[(int'(addr) + i) % 32] = w;
                for (int b = 19; b >= 0; b--) exp_q.push_back(w[b]);
            end
        end else begin
            for (int i = 0; i < 20; i++) exp_q.push_back(1'b0);
        end
        n_bits   = (len == 0) ? 0 : 6 + 20 * len + (rw ? 0 : 20);
        @(negedge CLOCK_50);
        a = cyc;
        iRW = rw; iADDR = addr; iLEN = 5'(len); iSTART = 1'b1;
        exp_done = (len == 0) ? a + 1 : a + 1 + D * (2 * n_bits + 2);
        got = 1'b0;
        for (int k = 0; k < exp_done - a + 40 && !got; k++) begin
            @(negedge CLOCK_50);
            if (cyc == a + 1) iSTART = 1'b0;
            if (oDONE) got = 1'b1;
        end
        iSTART = 1'b0;
        @(negedge CLOCK_50);
        vectors++;
        if (!got) begin miscompares++; $display("FAIL %s done_timeout no oDONE within budget", tag); end
        vectors++;
        if (done_cyc != exp_done) begin miscompares++; $display("FAIL %s done_cycle got %0d exp %0d", tag, done_cyc - a, exp_done - a); end
        vectors++;
        if (oBUSY !== 1'b0 || CS !== 1'b1) begin miscompares++; $display("FAIL %s after_done busy=%b cs=%b exp busy=0 cs=1", tag, oBUSY, CS); end
        vectors++;
        if (busy_rise != a + 1) begin miscompares++; $display("FAIL %s busy_rise got %0d exp %0d", tag, busy_rise - a, 1); end
        vectors++;
        if (len > 0) begin
            if (cs_fall_cnt != 1 || cs_fall_cyc != a + 1 || first_rise != a + 1 + D) begin
                miscompares++;
                $display("FAIL %s cs_sclk_start cs_falls=%0d cs_fall=%0d first_rise=%0d exp 1,%0d,%0d",
                         tag, cs_fall_cnt, cs_fall_cyc - a, first_rise - a, 1, 1 + D);
            end
        end else if (cs_fall_cnt != 0 || first_rise != -1) begin
            miscompares++;
            $display("FAIL %s len0_activity cs_falls=%0d sclk_rise=%0d exp 0,-1", tag, cs_fall_cnt, first_rise);
        end
        vectors++;
        if (mosi_q.size() != n_bits) begin miscompares++; $display("FAIL %s sclk_rises got %0d exp %0d", tag, mosi_q.size(), n_bits); end
        nbad = 0;
        lim = rw ? n_bits : ((len > 0) ? 26 : 0);
        for (int i = 0; i < lim && i < mosi_q.size(); i++) if (mosi_q[i] !== exp_q[i]) nbad++;
        vectors++;
        if (nbad != 0) begin miscompares++; $display("FAIL %s mosi_stream bad_bits got %0d exp 0", tag, nbad); end
        vectors++;
        if (req_cnt != (rw ? len : 0)) begin miscompares++; $display("FAIL %s data_req_count got %0d exp %0d", tag, req_cnt, rw ? len : 0); end
        nbad = 0;
        for (int i = 0; i < rd_q.size() && i < len; i++) if (rd_q[i] !== ref_mem[(int'(addr) + i) % 32]) nbad++;
        vectors++;
        if (rd_q.size() != (rw ? 0 : len) || nbad != 0) begin
            miscompares++;
            $display("FAIL %s read_words count got %0d exp %0d bad_words %0d", tag, rd_q.size(), rw ? 0 : len, nbad);
        end
        vectors++;
        if (cs_bad != 0) begin miscompares++; $display("FAIL %s sclk_rise_outside_cs got %0d exp 0", tag, cs_bad); end
    endtask

    task automatic test_reset();
        iRSTn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        vectors++;
        if (CS !== 1'b1 || SCLK !== 1'b0 || MOSI !== 1'b0) begin
            miscompares++; $display("FAIL reset_pins cs=%b sclk=%b mosi=%b exp 1 0 0", CS, SCLK, MOSI);
        end
        vectors++;
        if (oDATA !== 20'd0 || oDATA_REQ !== 1'b0 || oDATA_VALID !== 1'b0 ||
            oBUSY !== 1'b0 || oDONE !== 1'b0 || oERR !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs data=%h req=%b valid=%b busy=%b done=%b err=%b exp all 0",
                     oDATA, oDATA_REQ, oDATA_VALID, oBUSY, oDONE, oERR);
        end
        iRSTn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic test_write_directed();
        logic [25:0] exp_bits;
        int nbad;
        exp_bits = 26'b100011_10100101101001011010;
        stim_q.delete();
        stim_q.push_back(20'hA5A5A);
        do_transfer(1'b1, 5'd3, 1, "write_1word");
        nbad = 0;
        for (int i = 0; i < 26 && i < mosi_q.size(); i++) if (mosi_q[i] !== exp_bits[25 - i]) nbad++;
        vectors++;
        if (nbad != 0 || mosi_q.size() != 26) begin miscompares++; $display("FAIL write_1word literal_stream bad %0d size %0d exp 0 26", nbad, mosi_q.size()); end
        vectors++;
        if (mem[3] !== 20'hA5A5A) begin miscompares++; $display("FAIL write_1word responder_mem got %h exp a5a5a", mem[3]); end
    endtask

    task automatic test_read_directed();
        for (int i = 0; i < 3; i++) begin
            mem[i]     = 20'(i + 1);
            ref_mem[i] = 20'(i + 1);
        end
        do_transfer(1'b0, 5'd0, 3, "read_3words");
        vectors++;
        if (rd_q.size() != 3 || rd_q[0] !== 20'd1 || rd_q[1] !== 20'd2 || rd_q[2] !== 20'd3) begin
            miscompares++; $display("FAIL read_3words values size=%0d exp 1,2,3", rd_q.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int len;
            logic [4:0] addr;
            len  = $urandom_range(1, 6);
            addr = 5'($urandom_range(0, DEPTH - len));
            stim_q.delete();
            for (int i = 0; i < len; i++) stim_q.push_back(20'($urandom));
            do_transfer(1'b1, addr, len, "rand_write");
            do_transfer(1'b0, addr, len, "rand_readback");
        end
    endtask

    task automatic test_range();
`ifdef SPI_MEM_MASTER_RANGE_CHECK_EN
        int a;
        clear_mon();
        @(negedge CLOCK_50);
        a = cyc;
        iRW = 1'b1; iADDR = 5'd27; iLEN = 5'd3; iSTART = 1'b1;
        @(negedge CLOCK_50);
        iSTART = 1'b0;
        repeat (300) @(negedge CLOCK_50);
        vectors++;
        if (err_cnt != 1 || err_cyc != a + 1) begin miscompares++; $display("FAIL range_err pulses=%0d at=%0d exp 1 at 1", err_cnt, err_cyc - a); end
        vectors++;
        if (done_cnt != 0 || cs_fall_cnt != 0 || busy_rise != -1) begin
            miscompares++; $display("FAIL range_quiet done=%0d cs_falls=%0d busy_rise=%0d exp 0 0 -1", done_cnt, cs_fall_cnt, busy_rise);
        end
`else
        stim_q.delete();
        for (int i = 0; i < 3; i++) stim_q.push_back(20'($urandom));
        do_transfer(1'b1, 5'd27, 3, "range_unchecked");
        vectors++;
        if (oERR !== 1'b0 || err_cnt != 0) begin miscompares++; $display("FAIL range_unchecked err got %0d exp 0", err_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [19:0] w [2];
        logic [5:0]  h;
        bit   exp_q [$];
        int a, d1, d2, nd, nbad;
        clear_mon();
        h = {1'b1, 5'd20};
        for (int t = 0; t < 2; t++) begin
            w[t] = 20'($urandom);
            wr_q.push_back(w[t]);
            for (int b = 5; b >= 0; b--) exp_q.push_back(h[b]);
            for (int b = 19; b >= 0; b--) exp_q.push_back(w[t][b]);
        end
        ref_mem[20] = w[1];
        @(negedge CLOCK_50);
        a = cyc;
        iRW = 1'b1; iADDR = 5'd20; iLEN = 5'd1; iSTART = 1'b1;
        d1 = -1; d2 = -1; nd = 0;
        for (int k = 0; k < 700 && nd < 2; k++) begin
            @(negedge CLOCK_50);
            if (oDONE) begin
                nd++;
                if (nd == 1) d1 = cyc; else begin d2 = cyc; iSTART = 1'b0; end
            end
        end
        iSTART = 1'b0;
        repeat (300) @(negedge CLOCK_50);
        vectors++;
        if (d1 != a + 1 + D * 54 || d2 != d1 + 2 + D * 54) begin
            miscompares++; $display("FAIL b2b_timing done1=%0d done2_gap=%0d exp %0d %0d", d1 - a, d2 - d1, 1 + D * 54, 2 + D * 54);
        end
        vectors++;
        if (cs_fall_cnt != 2 || done_cnt != 2 || req_cnt != 2) begin
            miscompares++; $display("FAIL b2b_counts cs_windows=%0d dones=%0d reqs=%0d exp 2 2 2", cs_fall_cnt, done_cnt, req_cnt);
        end
        nbad = 0;
        for (int i = 0; i < 52 && i < mosi_q.size(); i++) if (mosi_q[i] !== exp_q[i]) nbad++;
        vectors++;
        if (nbad != 0 || mosi_q.size() != 52) begin miscompares++; $display("FAIL b2b_stream bad %0d size %0d exp 0 52", nbad, mosi_q.size()); end
    endtask

    task automatic test_len0();
        do_transfer(1'b1, 5'd5, 0, "len0");
    endtask

    task automatic test_reset_mid();
        int nreq;
        clear_mon();
        for (int i = 0; i < 4; i++) wr_q.push_back(20'($urandom));
        @(negedge CLOCK_50);
        iRW = 1'b1; iADDR = 5'd10; iLEN = 5'd4; iSTART = 1'b1;
        @(negedge CLOCK_50);
        iSTART = 1'b0;
        nreq = 0;
        for (int k = 0; k < 600 && nreq < 2; k++) begin
            @(negedge CLOCK_50);
            if (oDATA_REQ) nreq++;
        end
        vectors++;
        if (nreq != 2) begin miscompares++; $display("FAIL reset_mid req_wait got %0d exp 2", nreq); end
        repeat (30) @(negedge CLOCK_50);
        iRSTn = 1'b0;
        @(negedge CLOCK_50);
        vectors++;
        if (CS !== 1'b1 || SCLK !== 1'b0 || oBUSY !== 1'b0 || MOSI !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid abort cs=%b sclk=%b busy=%b mosi=%b exp 1 0 0 0", CS, SCLK, oBUSY, MOSI);
        end
        iRSTn = 1'b1;
        repeat (400) @(negedge CLOCK_50);
        vectors++;
        if (done_cnt != 0) begin miscompares++; $display("FAIL reset_mid spurious_done got %0d exp 0", done_cnt); end
        stim_q.delete();
        stim_q.push_back(20'($urandom));
        do_transfer(1'b1, 5'd12, 1, "after_reset_write");
        do_transfer(1'b0, 5'd12, 1, "after_reset_read");
    endtask

    initial begin
        test_reset();
        test_write_directed();
        test_read_directed();
        test_random();
        test_range();
        test_back_to_back();
        test_len0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
